lcd_frame_writer: RTL and testbench
===================================

// Module: lcd_frame_writer
// PURPOSE
//  Parametrised Avalon-MM master that drives the character-LCD controller IP (HD44780-style).
//  Holds an N_ROWS x N_COLS character frame buffer loaded by user logic.
//  On request, or continuously when AUTO_REFRESH=1, it sends the init sequence once after reset,
//  then writes every row: one set-DDRAM-address instruction followed by the row's characters.
//  Successor to the fixed-string LCD writer; sits between application logic and the LCD IP slave port.
// PARAMETERS
//  N_ROWS        2   display rows, legal 1..4
//  N_COLS        16  characters per row, legal 1..40
//  AUTO_REFRESH  0   1: restart the frame automatically after done; 0: one frame per start
// PORTS
//  clk          in   1   system clock (50 MHz)
//  reset        in   1   synchronous, active-high
//  start        in   1   request one frame write; sampled only in IDLE
//  busy         out  1   high while a frame (incl. init) is in progress
//  done         out  1   1-cycle pulse after the last transfer of a frame is accepted
//  buf_we       in   1   frame-buffer write strobe
//  buf_addr     in   AW  AW=$clog2(N_ROWS*N_COLS); index = row*N_COLS+col
//  buf_wdata    in   8   ASCII character
//  address      out  1   0 = instruction register, 1 = data register
//  chipselect   out  1   equals write
//  byteenable   out  1   constant 1
//  read         out  1   constant 0
//  write        out  1   Avalon write request
//  waitrequest  in   1   slave stall
//  writedata    out  8   instruction or character
// BEHAVIOUR
//  Reset: write, chipselect, busy, done, address, writedata = 0; byteenable = 1; read = 0.
//   State IDLE; inited flag cleared; every buffer entry set to 8'h20 (space).
//  Handshake: write and chipselect rise together. address and writedata are registered and held
//   stable until the cycle in which write=1 and waitrequest=0 (accept). The next transfer may be
//   presented in the cycle after accept (back-to-back; no idle cycle is required).
//  FSM: IDLE -> (start) -> INIT if !inited, otherwise ROW_ADDR.
//   INIT: address=0, issues 0x38, 0x0C, 0x01, 0x06 in that order; then sets inited and goes to ROW_ADDR.
//   ROW_ADDR: address=0, writedata=0x80|base(row). Bases: row0=0x00, row1=0x40,
//    row2=N_COLS, row3=0x40+N_COLS. Goes to CHAR.
//   CHAR: address=1, writes N_COLS characters for col 0..N_COLS-1. Then next row's ROW_ADDR,
//    or DONE after the last row.
//   DONE: done=1 for exactly 1 cycle, busy=0 in that same cycle. Next state is ROW_ADDR when
//    AUTO_REFRESH=1, else IDLE.
//  Latency: write is first high 1 cycle after start is sampled in IDLE; busy rises in the same cycle.
//  Transfers per frame: 4*(!inited) + N_ROWS*(1+N_COLS); 2x16 gives 38 on the first frame, 34 thereafter.
//  start is ignored while busy or in DONE; it is not queued.
//  Frame buffer: buf_we allowed at any time, including mid-frame.
//   A character is captured into writedata when its transfer is first presented.
//   Later buffer writes do not alter a pending transfer.
//   buf_we with buf_addr >= N_ROWS*N_COLS is ignored.
//  Reset mid-frame: write drops on the cycle after reset is sampled, no done pulse, inited=0.
//   The next start therefore re-runs INIT.
//  The block never asserts read and never issues a transfer outside INIT, ROW_ADDR or CHAR.
// TESTING
//  1. Reset, then load "HELLO" at row0 col0..4, pulse start, waitrequest=0:
//     38 transfers: 38,0C,01,06 (addr0); 80; H,E,L,L,O + 11 spaces; C0; 16 spaces; done 1 cycle.
//  2. Random waitrequest stalls (37.5%) on every transfer:
//     same transfer sequence as case 1; writedata and address never change while stalled.
//  3. Second start after case 1: exactly 34 transfers with no INIT and first writedata=0x80;
//     start pulsed while busy produces no extra frame.
//  4. buf_we to row1 col0 ('Z') while row0 is being sent: row1 col0 transfers 'Z';
//     buf_we to row0 col0 after its accept does not resend it.
//  5. Assert reset during the CHAR state of row0: write=0 next cycle, no done;
//     the next start re-issues the 38 instructions starting with INIT.
//  6. N_ROWS=4, N_COLS=20, AUTO_REFRESH=1: row addresses 80,C0,94,D4;
//     done pulses once per 84-transfer frame, frames repeat without start.

Source files
------------

// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: Avalon-MM master that streams an N_ROWS x N_COLS character frame to an
// HD44780-style LCD controller. It sends the init sequence once after reset, then one frame per start.
module lcd_frame_writer #(
    parameter int N_ROWS       = 2,
    parameter int N_COLS       = 16,
    parameter bit AUTO_REFRESH = 1'b0,
    localparam int DEPTH = N_ROWS * N_COLS,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          buf_we,
    input  logic [AW-1:0] buf_addr,
    input  logic [7:0]    buf_wdata,
    output logic          address,
    output logic          chipselect,
    output logic          byteenable,
    output logic          read,
    output logic          write,
    input  logic          waitrequest,
    output logic [7:0]    writedata
);

    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;

    typedef enum logic [2:0] {IDLE, INIT, ROW_ADDR, CHAR, DONE} state_t;

    state_t          state_q, state_d;
    logic            inited_q, inited_d;
    logic [1:0]      initIdx_q, initIdx_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   nextPtr;
    logic [7:0]      wdata_q, wdata_d;
    logic            addr_q, addr_d;
    logic            accept;
    logic [7:0]      frameBuf [DEPTH];

    function automatic logic [7:0] initCmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Rows 2 and 3 of a 4-line module continue rows 0 and 1 at DDRAM offset N_COLS.
    function automatic logic [7:0] rowCmd(input logic [RW-1:0] r);
        logic [7:0] base;
        base = 8'h00;
        case (32'(r))
            1:       base = 8'h40;
            2:       base = 8'(N_COLS);
            3:       base = 8'(64 + N_COLS);
            default: base = 8'h00;
        endcase
        return 8'h80 | base;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            inited_q  <= 1'b0;
            initIdx_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            ptr_q     <= '0;
            wdata_q   <= 8'h00;
            addr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            inited_q  <= inited_d;
            initIdx_q <= initIdx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                frameBuf[i] <= 8'h20;
            end
        end else if (buf_we && (32'(buf_addr) < DEPTH)) begin
            frameBuf[buf_addr] <= buf_wdata;
        end
    end

    // Each transfer's payload is latched the moment it is presented, so later buffer writes cannot disturb it.
    always_comb begin
        state_d   = state_q;
        inited_d  = inited_q;
        initIdx_d = initIdx_q;
        row_d     = row_q;
        col_d     = col_q;
        ptr_d     = ptr_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        nextPtr   = ptr_q + AW'(1);
        accept    = write && !waitrequest;

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d  = '0;
                    ptr_d  = '0;
                    addr_d = 1'b0;
                    if (inited_q) begin
                        state_d = ROW_ADDR;
                        wdata_d = rowCmd('0);
                    end else begin
                        state_d   = INIT;
                        initIdx_d = 2'd0;
                        wdata_d   = initCmd(2'd0);
                    end
                end
            end
            INIT: begin
                if (accept) begin
                    if (initIdx_q == 2'd3) begin
                        inited_d = 1'b1;
                        state_d  = ROW_ADDR;
                        row_d    = '0;
                        ptr_d    = '0;
                        wdata_d  = rowCmd('0);
                    end else begin
                        initIdx_d = initIdx_q + 2'd1;
                        wdata_d   = initCmd(initIdx_q + 2'd1);
                    end
                end
            end
            ROW_ADDR: begin
                if (accept) begin
                    state_d = CHAR;
                    col_d   = '0;
                    addr_d  = 1'b1;
                    wdata_d = frameBuf[ptr_q];
                end
            end
            CHAR: begin
                if (accept) begin
                    ptr_d = nextPtr;
                    if (col_q != CW'(N_COLS - 1)) begin
                        col_d   = col_q + CW'(1);
                        wdata_d = frameBuf[nextPtr];
                    end else if (row_q != RW'(N_ROWS - 1)) begin
                        state_d = ROW_ADDR;
                        row_d   = row_q + RW'(1);
                        addr_d  = 1'b0;
                        wdata_d = rowCmd(row_q + RW'(1));
                    end else begin
                        state_d = DONE;
                        addr_d  = 1'b0;
                    end
                end
            end
            DONE: begin
                if (AUTO_REFRESH) begin
                    state_d = ROW_ADDR;
                    row_d   = '0;
                    ptr_d   = '0;
                    addr_d  = 1'b0;
                    wdata_d = rowCmd('0);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write      = (state_q == INIT) || (state_q == ROW_ADDR) || (state_q == CHAR);
        chipselect = write;
        busy       = write;
        done       = (state_q == DONE);
        address    = addr_q;
        writedata  = wdata_q;
        byteenable = 1'b1;
        read       = 1'b0;
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb_lcd_frame_writer: directed, table-driven checks of lcd_frame_writer in a 2x16 one-shot
// configuration (dutA) and a 4x20 auto-refresh configuration (dutB).
module tb_lcd_frame_writer;

    typedef struct {
        int         stall;
        logic       expAddr;
        logic [7:0] expData;
    } vec_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       resetA, resetB, start, sel, bufWe, waitrequest;
    logic [6:0] bufAddr;
    logic [7:0] bufWdata;
    logic       startA, startB, weA, weB;

    logic       busyA, doneA, addressA, csA, beA, readA, writeA;
    logic [7:0] wdataA;
    logic       busyB, doneB, addressB, csB, beB, readB, writeB;
    logic [7:0] wdataB;

    logic       mBusy, mDone, mAddr, mCs, mBe, mRead, mWrite;
    logic [7:0] mData;

    int   vectors = 0;
    int   misses  = 0;
    vec_t vecs[$];
    logic [7:0] model [80];
    int   hookIdx  [3];
    logic [6:0] hookAddr [3];
    logic [7:0] hookData [3];

    assign startA = start && !sel;
    assign startB = start && sel;
    assign weA    = bufWe && !sel;
    assign weB    = bufWe && sel;

    assign mBusy  = sel ? busyB    : busyA;
    assign mDone  = sel ? doneB    : doneA;
    assign mAddr  = sel ? addressB : addressA;
    assign mCs    = sel ? csB      : csA;
    assign mBe    = sel ? beB      : beA;
    assign mRead  = sel ? readB    : readA;
    assign mWrite = sel ? writeB   : writeA;
    assign mData  = sel ? wdataB   : wdataA;

    lcd_frame_writer #(.N_ROWS(2), .N_COLS(16), .AUTO_REFRESH(1'b0)) dutA (
        .clk(clk), .reset(resetA), .start(startA), .busy(busyA), .done(doneA),
        .buf_we(weA), .buf_addr(bufAddr[4:0]), .buf_wdata(bufWdata),
        .address(addressA), .chipselect(csA), .byteenable(beA), .read(readA),
        .write(writeA), .waitrequest(waitrequest), .writedata(wdataA)
    );

    lcd_frame_writer #(.N_ROWS(4), .N_COLS(20), .AUTO_REFRESH(1'b1)) dutB (
        .clk(clk), .reset(resetB), .start(startB), .busy(busyB), .done(doneB),
        .buf_we(weB), .buf_addr(bufAddr), .buf_wdata(bufWdata),
        .address(addressB), .chipselect(csB), .byteenable(beB), .read(readB),
        .write(writeB), .waitrequest(waitrequest), .writedata(wdataB)
    );

    // Safety net so a stuck design still ends the run with a reported failure.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] obs();
        return {3'b000, mBusy, mDone, mWrite, mCs, mAddr, mData};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 80; i++) model[i] = 8'h20;
    endtask

    task automatic applyStimulus(input logic [6:0] addr, input logic [7:0] data, input int depth);
        bufWe    = 1'b1;
        bufAddr  = addr;
        bufWdata = data;
        @(negedge clk);
        bufWe = 1'b0;
        if (int'(addr) < depth) model[addr] = data;
    endtask

    task automatic loadHello();
        string s;
        s = "HELLO";
        for (int i = 0; i < 5; i++) applyStimulus(7'(i), s[i], 32);
    endtask

    function automatic int pickStall(input bit randStall);
        if (!randStall) return 0;
        return ($urandom_range(0, 7) < 3) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    // Expected transfer list derived from the init constants, the DDRAM row map and the model buffer.
    task automatic buildFrame(input bit withInit, input int nRows, input int nCols, input bit randStall);
        logic [7:0] initSeq [4];
        int base;
        initSeq = '{8'h38, 8'h0C, 8'h01, 8'h06};
        vecs.delete();
        if (withInit) begin
            for (int i = 0; i < 4; i++)
                vecs.push_back('{stall: pickStall(randStall), expAddr: 1'b0, expData: initSeq[i]});
        end
        for (int r = 0; r < nRows; r++) begin
            base = (r == 0) ? 0 : (r == 1) ? 64 : (r == 2) ? nCols : 64 + nCols;
            vecs.push_back('{stall: pickStall(randStall), expAddr: 1'b0, expData: 8'h80 | 8'(base)});
            for (int c = 0; c < nCols; c++)
                vecs.push_back('{stall: pickStall(randStall), expAddr: 1'b1, expData: model[r*nCols + c]});
        end
    endtask

    task automatic runFrame(input int startPulseIdx);
        logic [15:0] exp;
        for (int i = 0; i < vecs.size(); i++) begin
            exp   = {3'b000, 4'b1011, vecs[i].expAddr, vecs[i].expData};
            start = (i == startPulseIdx);
            for (int h = 0; h < 3; h++) begin
                if (hookIdx[h] == i) begin
                    bufWe    = 1'b1;
                    bufAddr  = hookAddr[h];
                    bufWdata = hookData[h];
                end
            end
            checkOutput($sformatf("xfer%0d", i), obs(), exp);
            if (vecs[i].stall > 0) begin
                waitrequest = 1'b1;
                for (int s = 0; s < vecs[i].stall; s++) begin
                    @(negedge clk);
                    start = 1'b0;
                    bufWe = 1'b0;
                    checkOutput($sformatf("stall%0d", i), obs(), exp);
                end
                waitrequest = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
            bufWe = 1'b0;
        end
    endtask

    task automatic checkEnd(input string name, input bit autoNext, input bit pokeStart);
        checkOutput({name, " done"}, 16'({mBusy, mDone, mWrite}), 16'(3'b010));
        start = pokeStart;
        @(negedge clk);
        start = 1'b0;
        if (!autoNext)
            checkOutput({name, " idle"}, 16'({mBusy, mDone, mWrite}), 16'(3'b000));
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        bit flag;
        int g;
        sel = 1'b0; resetA = 1'b1; resetB = 1'b1; start = 1'b0;
        bufWe = 1'b0; bufAddr = '0; bufWdata = '0; waitrequest = 1'b0;
        for (int h = 0; h < 3; h++) begin hookIdx[h] = -1; hookAddr[h] = '0; hookData[h] = '0; end
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", 16'({mBusy, mDone, mWrite, mCs, mAddr, mRead, mBe, mData}),
                    16'({7'b0000001, 8'h00}));
        resetA = 1'b0; resetB = 1'b0;
        @(negedge clk);

        // First frame after reset includes INIT: 38 transfers with no stalls.
        clearModel();
        loadHello();
        checkOutput("idle before start", 16'({mBusy, mWrite}), 16'(2'b00));
        buildFrame(1'b1, 2, 16, 1'b0);
        pulseStart();
        runFrame(-1);
        checkEnd("frame1", 1'b0, 1'b0);

        // Second frame skips INIT; starts in busy and in DONE must not queue another frame.
        buildFrame(1'b0, 2, 16, 1'b0);
        pulseStart();
        runFrame(10);
        checkEnd("frame2", 1'b0, 1'b1);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mWrite || mBusy || mDone) flag = 1'b1;
        end
        checkOutput("no queued start", 16'(flag), 16'(1'b0));

        // Mid-frame buffer writes: ahead of the pointer, behind it, and onto a stalled pending char.
        model[16] = "Z";
        buildFrame(1'b0, 2, 16, 1'b0);
        vecs[5].stall = 2;
        hookIdx[0] = 3; hookAddr[0] = 7'd16; hookData[0] = "Z";
        hookIdx[1] = 2; hookAddr[1] = 7'd0;  hookData[1] = "#";
        hookIdx[2] = 5; hookAddr[2] = 7'd4;  hookData[2] = "!";
        pulseStart();
        runFrame(-1);
        for (int h = 0; h < 3; h++) hookIdx[h] = -1;
        checkEnd("frame3", 1'b0, 1'b0);

        // Reset while row 0 characters are going out, then a full re-init frame with random stalls.
        pulseStart();
        g = 0;
        while (!(mWrite && mAddr) && g < 40) begin
            @(negedge clk);
            g++;
        end
        checkOutput("reach row0 CHAR", 16'({mWrite, mAddr}), 16'(2'b11));
        resetA = 1'b1;
        @(negedge clk);
        checkOutput("reset mid-frame", 16'({mBusy, mDone, mWrite}), 16'(3'b000));
        resetA = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mWrite || mDone) flag = 1'b1;
        end
        checkOutput("quiet after reset", 16'(flag), 16'(1'b0));
        clearModel();
        loadHello();
        buildFrame(1'b1, 2, 16, 1'b1);
        pulseStart();
        runFrame(-1);
        checkEnd("frame4", 1'b0, 1'b0);

        // 4x20 auto-refresh instance: init frame then a second frame with no start.
        sel = 1'b1;
        clearModel();
        applyStimulus(7'd40, "A", 80);
        applyStimulus(7'd79, "B", 80);
        applyStimulus(7'd127, "Q", 80);
        buildFrame(1'b1, 4, 20, 1'b0);
        pulseStart();
        runFrame(-1);
        checkEnd("autoFrame1", 1'b1, 1'b0);
        buildFrame(1'b0, 4, 20, 1'b1);
        runFrame(-1);
        checkEnd("autoFrame2", 1'b1, 1'b0);
        checkOutput("auto restart", obs(), {3'b000, 4'b1011, 1'b0, 8'h80});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
